// File: rtl/spi_frame_monitor_if.sv
// Slave-side SPI pins plus the wrapper's rx_valid/rx_data handshake.
// The bus driver uses master; the passive frame monitor uses slave.
interface spi_frame_monitor_if #(
  parameter int unsigned FRAME_W = 10
) ();
  logic               ss_n;
  logic               mosi;
  logic               miso;
  logic               rx_valid;
  logic [FRAME_W-1:0] rx_data;

  modport master (output ss_n, output mosi, output miso, output rx_valid, output rx_data);
  modport slave  (input  ss_n, input  mosi, input  miso, input  rx_valid, input  rx_data);
endinterface

// File: rtl/spi_frame_monitor.sv
// Passive SPI wrapper frame checker: validates rx_valid latency/payload, captures
// read returns, flags aborts and slave-select timeouts, counts frames per command.
module spi_frame_monitor #(
  parameter int unsigned      CMD_W      = 2,
  parameter int unsigned      DATA_W     = 8,
  parameter int unsigned      RXV_LAT    = 1,
  parameter int unsigned      SS_TIMEOUT = 16,
  parameter logic [CMD_W-1:0] READ_CMD   = CMD_W'(2'b11),
  parameter int unsigned      CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  spi_frame_monitor_if.slave            bus,
  input  logic                          err_clr,
  output logic                          frame_done,
  output logic [CMD_W-1:0]              frame_cmd,
  output logic [DATA_W-1:0]             frame_data,
  output logic                          rd_done,
  output logic [DATA_W-1:0]             rd_data,
  output logic [4:0]                    err_pulse,
  output logic [4:0]                    err_sticky,
  output logic [(2**CMD_W)*CNT_W-1:0]   cmd_cnt
);

  localparam int unsigned FRAME_W = CMD_W + DATA_W;
  localparam int unsigned NCMD    = 2**CMD_W;
  localparam int unsigned CNT_ALL = NCMD * CNT_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned TMO_W   = $clog2(SS_TIMEOUT + 1);
  localparam int unsigned LAT_W   = 3;

  localparam int unsigned E_ABORT = 0;
  localparam int unsigned E_MISS  = 1;
  localparam int unsigned E_SPUR  = 2;
  localparam int unsigned E_DATA  = 3;
  localparam int unsigned E_TMO   = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    SHIFT    = 3'd2,
    WAIT_RXV = 3'd3,
    READ     = 3'd4,
    WAIT_SS  = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic                 ss_n_d;
  logic [FRAME_W-1:0]   sh, sh_nxt;
  logic [DATA_W-1:0]    rsh, rsh_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [LAT_W-1:0]     lat, lat_nxt;
  logic [TMO_W-1:0]     tmo, tmo_nxt;

  logic                 frame_done_nxt;
  logic [CMD_W-1:0]     frame_cmd_nxt;
  logic [DATA_W-1:0]    frame_data_nxt;
  logic                 rd_done_nxt;
  logic [DATA_W-1:0]    rd_data_nxt;
  logic [4:0]           err_nxt;
  logic [CNT_ALL-1:0]   cnt_nxt;

  logic [CMD_W-1:0]     sh_cmd;
  logic [DATA_W-1:0]    sh_data;

  assign sh_cmd  = sh[FRAME_W-1 -: CMD_W];
  assign sh_data = sh[DATA_W-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, datapath and error decode
  always_comb begin
    state_nxt      = state;
    sh_nxt         = sh;
    rsh_nxt        = rsh;
    bit_cnt_nxt    = bit_cnt;
    lat_nxt        = lat;
    tmo_nxt        = tmo;
    frame_done_nxt = 1'b0;
    frame_cmd_nxt  = frame_cmd;
    frame_data_nxt = frame_data;
    rd_done_nxt    = 1'b0;
    rd_data_nxt    = rd_data;
    err_nxt        = '0;
    cnt_nxt        = cmd_cnt;

    unique case (state)
      IDLE: begin
        if (bus.rx_valid) err_nxt[E_SPUR] = 1'b1;
        if (!bus.ss_n && ss_n_d) state_nxt = START;
      end

      START: begin
        if (bus.rx_valid) err_nxt[E_SPUR] = 1'b1;
        if (bus.ss_n) begin
          err_nxt[E_ABORT] = 1'b1;
          state_nxt        = IDLE;
        end else begin
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.rx_valid) err_nxt[E_SPUR] = 1'b1;
        if (bus.ss_n) begin
          err_nxt[E_ABORT] = 1'b1;
          state_nxt        = IDLE;
        end else begin
          sh_nxt = FRAME_W'({sh, bus.mosi});
          if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
            lat_nxt   = LAT_W'(1);
            state_nxt = WAIT_RXV;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      WAIT_RXV: begin
        if (bus.ss_n) begin
          err_nxt[E_ABORT] = 1'b1;
          state_nxt        = IDLE;
        end else if (bus.rx_valid) begin
          tmo_nxt = '0;
          if (lat == LAT_W'(RXV_LAT)) begin
            // Accepted: a payload mismatch is flagged but the frame still counts
            frame_done_nxt = 1'b1;
            frame_cmd_nxt  = sh_cmd;
            frame_data_nxt = sh_data;
            if (bus.rx_data != sh) err_nxt[E_DATA] = 1'b1;
            for (int unsigned c = 0; c < NCMD; c++) begin
              if (CMD_W'(c) == sh_cmd && cnt_nxt[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})
                cnt_nxt[c*CNT_W +: CNT_W] = cnt_nxt[c*CNT_W +: CNT_W] + CNT_W'(1);
            end
            if (sh_cmd == READ_CMD) begin
              bit_cnt_nxt = '0;
              state_nxt   = READ;
            end else begin
              state_nxt = WAIT_SS;
            end
          end else begin
            err_nxt[E_SPUR] = 1'b1;
            state_nxt       = WAIT_SS;
          end
        end else if (lat == LAT_W'(RXV_LAT)) begin
          err_nxt[E_MISS] = 1'b1;
          tmo_nxt         = '0;
          state_nxt       = WAIT_SS;
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end

      READ: begin
        if (bus.rx_valid) err_nxt[E_SPUR] = 1'b1;
        if (bus.ss_n) begin
          err_nxt[E_ABORT] = 1'b1;
          state_nxt        = IDLE;
        end else begin
          rsh_nxt = DATA_W'({rsh, bus.miso});
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            rd_done_nxt = 1'b1;
            rd_data_nxt = rsh_nxt;
            tmo_nxt     = '0;
            state_nxt   = WAIT_SS;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      WAIT_SS: begin
        if (bus.rx_valid) err_nxt[E_SPUR] = 1'b1;
        if (bus.ss_n) begin
          state_nxt = IDLE;
        end else if (tmo == TMO_W'(SS_TIMEOUT - 1)) begin
          // ss_n_d stays low, so a new frame needs a fresh falling edge
          err_nxt[E_TMO] = 1'b1;
          state_nxt      = IDLE;
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_n_d     <= 1'b1;
      sh         <= '0;
      rsh        <= '0;
      bit_cnt    <= '0;
      lat        <= '0;
      tmo        <= '0;
      frame_done <= 1'b0;
      frame_cmd  <= '0;
      frame_data <= '0;
      rd_done    <= 1'b0;
      rd_data    <= '0;
      err_pulse  <= '0;
      err_sticky <= '0;
      cmd_cnt    <= '0;
    end else begin
      ss_n_d     <= bus.ss_n;
      sh         <= sh_nxt;
      rsh        <= rsh_nxt;
      bit_cnt    <= bit_cnt_nxt;
      lat        <= lat_nxt;
      tmo        <= tmo_nxt;
      frame_done <= frame_done_nxt;
      frame_cmd  <= frame_cmd_nxt;
      frame_data <= frame_data_nxt;
      rd_done    <= rd_done_nxt;
      rd_data    <= rd_data_nxt;
      err_pulse  <= err_nxt;
      // A new error wins over a same-cycle clear
      err_sticky <= (err_clr ? 5'd0 : err_sticky) | err_nxt;
      cmd_cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_spi_frame_monitor.sv
// Directed and randomized frames against a frame-level reference model; a second
// monitor with 2-bit counters shares the same bus to check saturation.
module tb_spi_frame_monitor;

  logic clk = 1'b0;
  logic rst;
  logic err_clr;

  spi_frame_monitor_if #(.FRAME_W(10)) bus ();

  logic        frame_done, rd_done;
  logic [1:0]  frame_cmd;
  logic [7:0]  frame_data, rd_data;
  logic [4:0]  err_pulse, err_sticky;
  logic [63:0] cmd_cnt;

  logic        s_frame_done, s_rd_done;
  logic [1:0]  s_frame_cmd;
  logic [7:0]  s_frame_data, s_rd_data;
  logic [4:0]  s_err_pulse, s_err_sticky;
  logic [7:0]  s_cmd_cnt;

  spi_frame_monitor dut (
    .clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr),
    .frame_done(frame_done), .frame_cmd(frame_cmd), .frame_data(frame_data),
    .rd_done(rd_done), .rd_data(rd_data), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .cmd_cnt(cmd_cnt)
  );

  spi_frame_monitor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr),
    .frame_done(s_frame_done), .frame_cmd(s_frame_cmd), .frame_data(s_frame_data),
    .rd_done(s_rd_done), .rd_data(s_rd_data), .err_pulse(s_err_pulse),
    .err_sticky(s_err_sticky), .cmd_cnt(s_cmd_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;

  // Reference model: last accepted frame, last read byte, sticky errors, counts
  logic [1:0]  exp_cmd;
  logic [7:0]  exp_data;
  logic [7:0]  exp_rd;
  logic [4:0]  exp_sticky;
  int unsigned exp_cnt [4];
  int unsigned exp_sat [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_cmd = '0; exp_data = '0; exp_rd = '0; exp_sticky = '0;
    for (int c = 0; c < 4; c++) begin exp_cnt[c] = 0; exp_sat[c] = 0; end
  endtask

  task automatic model_accept(input logic [1:0] cmd, input logic [7:0] data);
    exp_cmd  = cmd;
    exp_data = data;
    if (exp_cnt[cmd] < 65535) exp_cnt[cmd] = exp_cnt[cmd] + 1;
    if (exp_sat[cmd] < 3)     exp_sat[cmd] = exp_sat[cmd] + 1;
  endtask

  task automatic check_regs();
    chk("frame_cmd", 64'(frame_cmd), 64'(exp_cmd));
    chk("frame_data", 64'(frame_data), 64'(exp_data));
    chk("rd_data", 64'(rd_data), 64'(exp_rd));
    chk("sat_frame_data", 64'(s_frame_data), 64'(exp_data));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("cmd_cnt[%0d]", c), 64'(cmd_cnt[c*16 +: 16]), 64'(exp_cnt[c]));
      chk($sformatf("sat_cmd_cnt[%0d]", c), 64'(s_cmd_cnt[c*2 +: 2]), 64'(exp_sat[c]));
    end
  endtask

  // One clock: the model's expected strobes for the edge, checked #1 after it
  task automatic cyc(input logic [4:0] ep, input logic fd, input logic rd);
    logic clr;
    clr = err_clr;
    @(posedge clk); #1;
    exp_sticky = (clr ? 5'd0 : exp_sticky) | ep;
    chk("err_pulse", 64'(err_pulse), 64'(ep));
    chk("frame_done", 64'(frame_done), 64'(fd));
    chk("rd_done", 64'(rd_done), 64'(rd));
    chk("err_sticky", 64'(err_sticky), 64'(exp_sticky));
    chk("sat_err_pulse", 64'(s_err_pulse), 64'(ep));
    chk("sat_frame_done", 64'(s_frame_done), 64'(fd));
    chk("sat_err_sticky", 64'(s_err_sticky), 64'(exp_sticky));
  endtask

  task automatic check_zero();
    chk("rst_err_pulse", 64'(err_pulse), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_rd_done", 64'(rd_done), 64'(0));
    chk("rst_err_sticky", 64'(err_sticky), 64'(0));
    check_regs();
  endtask

  // mode: 0 good, 1 rx_valid missing, 2 payload mismatch, 3 early rx_valid in SHIFT, 4 abort after 5 bits
  task automatic run_frame(input logic [1:0] cmd, input logic [7:0] data, input logic [7:0] mb,
                           input int mode, input bit hold, input bit clr_abort);
    logic [9:0] f;
    int         nb;
    f  = {cmd, data};
    nb = (mode == 4) ? 5 : 10;
    bus.ss_n = 1'b0;
    cyc(5'h00, 1'b0, 1'b0);
    bus.mosi = 1'($urandom_range(0, 1));
    cyc(5'h00, 1'b0, 1'b0);
    for (int i = 0; i < nb; i++) begin
      bus.mosi     = f[9-i];
      bus.rx_valid = (mode == 3 && i == 5);
      cyc((mode == 3 && i == 5) ? 5'h04 : 5'h00, 1'b0, 1'b0);
      bus.rx_valid = 1'b0;
    end
    bus.mosi = 1'($urandom_range(0, 1));
    if (mode == 4) begin
      bus.ss_n = 1'b1;
      err_clr  = clr_abort;
      cyc(5'h01, 1'b0, 1'b0);
      err_clr  = 1'b0;
      check_regs();
    end else begin
      if (mode == 1) begin
        cyc(5'h02, 1'b0, 1'b0);
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = (mode == 2) ? (f ^ 10'h001) : f;
        cyc((mode == 2) ? 5'h08 : 5'h00, 1'b1, 1'b0);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 10'($urandom);
        model_accept(cmd, data);
        check_regs();
        if (cmd == 2'b11) begin
          for (int i = 0; i < 8; i++) begin
            bus.miso = mb[7-i];
            cyc(5'h00, 1'b0, (i == 7));
          end
          exp_rd = mb;
          check_regs();
          chk("sat_rd_data", 64'(s_rd_data), 64'(mb));
        end
      end
      if (hold) begin
        repeat (15) cyc(5'h00, 1'b0, 1'b0);
        cyc(5'h10, 1'b0, 1'b0);
        repeat (3) cyc(5'h00, 1'b0, 1'b0);
      end
      bus.ss_n = 1'b1;
      cyc(5'h00, 1'b0, 1'b0);
      check_regs();
    end
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    bus.ss_n = 1'b1; bus.mosi = 1'b0; bus.miso = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    rst = 1'b0;
    cyc(5'h00, 1'b0, 1'b0);

    run_frame(2'b00, 8'hA5, 8'h00, 0, 1'b0, 1'b0);   // write
    run_frame(2'b11, 8'h3C, 8'h96, 0, 1'b0, 1'b0);   // read
    run_frame(2'b10, 8'h5A, 8'h00, 1, 1'b0, 1'b0);   // rx_valid missing
    run_frame(2'b00, 8'hA5, 8'h00, 2, 1'b0, 1'b0);   // payload mismatch
    run_frame(2'b01, 8'h0F, 8'h00, 3, 1'b0, 1'b0);   // spurious in SHIFT
    run_frame(2'b10, 8'hC3, 8'h00, 4, 1'b0, 1'b0);   // abort
    run_frame(2'b00, 8'h11, 8'h00, 0, 1'b1, 1'b0);   // ss timeout
    run_frame(2'b11, 8'h22, 8'h81, 0, 1'b1, 1'b0);   // read then timeout
    repeat (4) run_frame(2'b01, 8'h77, 8'h00, 0, 1'b0, 1'b0);   // saturate 2-bit counter

    err_clr = 1'b1;
    cyc(5'h00, 1'b0, 1'b0);
    err_clr = 1'b0;
    run_frame(2'b00, 8'h99, 8'h00, 4, 1'b0, 1'b1);   // clear collides with abort

    // Reset in the middle of SHIFT
    bus.ss_n = 1'b0;
    cyc(5'h00, 1'b0, 1'b0);
    cyc(5'h00, 1'b0, 1'b0);
    repeat (4) begin bus.mosi = 1'b1; cyc(5'h00, 1'b0, 1'b0); end
    rst = 1'b1; bus.ss_n = 1'b1;
    #2;
    model_reset();
    check_zero();
    @(posedge clk); #1;
    check_zero();
    rst = 1'b0;
    cyc(5'h00, 1'b0, 1'b0);
    run_frame(2'b10, 8'hE7, 8'h00, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      err_clr = ($urandom_range(0, 3) == 0);
      cyc(5'h00, 1'b0, 1'b0);
      err_clr = 1'b0;
      run_frame(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_monitor.md
# spi_frame_monitor

Synthesizable, parametrised SPI-wrapper frame monitor. It passively watches slave-side SPI pins plus the wrapper's rx_valid/rx_data handshake and checks every frame against the protocol. Checked properties:
- rx_valid latency and rx_data payload.
- Read-data MISO return.
- Frame abort and slave-select timeout.

It reports pulsed and sticky error flags and saturating per-command frame counters. It sits beside the SPI wrapper in simulation and on silicon debug builds; it never drives the bus.

## Interface
Parameters:
- CMD_W, 2, command bits at frame head
- DATA_W, 8, payload bits after the command; FRAME_W = CMD_W+DATA_W
- RXV_LAT, 1, required cycles from last MOSI bit sampled to rx_valid (1..7)
- SS_TIMEOUT, 16, max cycles after frame completion before ss_n must rise
- READ_CMD, 2'b11, command value for which the slave returns DATA_W MISO bits
- CNT_W, 16, frame counter width

Ports:
- clk  in  1  clock, all sampling on rising edge
- rst  in  1  asynchronous, active-high reset
- ss_n  in  1  slave select, active low
- mosi  in  1  master data
- miso  in  1  slave data
- rx_valid  in  1  wrapper payload-valid strobe
- rx_data  in  FRAME_W  wrapper payload
- err_clr  in  1  clears err_sticky
- frame_done  out  1  one-cycle pulse, frame accepted
- frame_cmd  out  CMD_W  command of last accepted frame
- frame_data  out  DATA_W  payload of last accepted frame
- rd_done  out  1  one-cycle pulse, read return captured
- rd_data  out  DATA_W  captured MISO byte
- err_pulse  out  5  one-cycle error strobes: [0] abort, [1] rxv_missing, [2] rxv_spurious, [3] data_mismatch, [4] ss_timeout
- err_sticky  out  5  OR-accumulated err_pulse
- cmd_cnt  out  (2**CMD_W)*CNT_W  per-command accepted-frame counters, command c at slice [c*CNT_W +: CNT_W]

## Operation
States:
- IDLE: ss_n_d is ss_n registered, reset value 1. A sample with ss_n=0 and ss_n_d=1 is a falling edge and moves to START. ss_n held low without an edge, such as after reset, stays IDLE.
- START: one cycle; mosi is ignored. Moves to SHIFT with bit_cnt=0.
- SHIFT: shifts mosi into sh, MSB first, each cycle. After FRAME_W samples, moves to WAIT_RXV with lat=1.
- WAIT_RXV:
  - lat increments each cycle.
  - rx_valid with lat==RXV_LAT: accept. If rx_data!=sh, also flag data_mismatch; the frame is still counted.
  - rx_valid with lat<RXV_LAT: rxv_spurious, go to WAIT_SS.
  - lat==RXV_LAT without rx_valid: rxv_missing, go to WAIT_SS.
- On accept:
  - frame_done pulses; frame_cmd/frame_data load from sh.
  - cmd_cnt[cmd] increments, saturating at all-ones.
  - Next state is READ if cmd==READ_CMD, else WAIT_SS.
- READ: samples miso DATA_W cycles, MSB first, starting the cycle after rx_valid. Then rd_done pulses, rd_data loads, and the block moves to WAIT_SS.
- WAIT_SS: tmo counts cycles.
  - ss_n=1 goes to IDLE.
  - tmo reaching SS_TIMEOUT flags ss_timeout and goes to IDLE. A new frame then requires a fresh falling edge.
- Abort: ss_n=1 while in START, SHIFT, WAIT_RXV or READ flags abort and goes to IDLE. Nothing is counted and rd_done does not fire.
- rx_valid in IDLE, START, SHIFT, READ or WAIT_SS flags rxv_spurious with no state change, except that the abort check still applies.
- err_sticky: sticky |= err_pulse each cycle; err_clr clears it. A same-cycle new error and err_clr leaves that error bit set.

## Timing
- All outputs are registered and appear one clock after the triggering sample edge.
- Reset values: every output 0, state IDLE, ss_n_d=1, all counters 0. Reset mid-frame discards the frame without reporting an error.
- Nominal frame for defaults, with ss_n falling sampled at T:
  - START at T+1.
  - Bits sampled T+2..T+11.
  - rx_valid required at T+11+RXV_LAT = T+12.
  - frame_done high at T+13.
  - Read frame: MISO bits at T+13..T+20, rd_done at T+21.
- Multiple errors in one cycle set every corresponding bit.
- Back-to-back frames: ss_n rising then falling on consecutive samples is legal; IDLE needs only one cycle.

## Test plan
- Write frame: cmd 2'b00, data 8'hA5, rx_valid at T+12 with rx_data 10'h0A5 -> frame_done at T+13, frame_cmd 0, frame_data A5, cmd_cnt[0]=1, err_sticky 0.
- Read frame: cmd 2'b11, data 8'h3C, correct rx_valid, MISO 8'h96 -> rd_done at T+21 with rd_data 96, cmd_cnt[3]=1.
- Latency faults:
  - rx_valid absent -> err_pulse[1] at T+13.
  - rx_valid at T+12 with rx_data 10'h0A4 -> err_pulse[3], frame still counted.
  - rx_valid during SHIFT -> err_pulse[2].
- Abort: ss_n rises after 5 bits -> err_pulse[0] next cycle, no count change. Then ss_n held low 20 cycles after an accepted frame -> err_pulse[4].
- Saturation and clear:
  - CNT_W=2, four cmd-01 frames -> cmd_cnt[1] stays 3.
  - err_clr asserted in the same cycle as a new abort -> err_sticky[0] remains 1.
- Reset mid-SHIFT -> all outputs 0 while rst is high. The next clean frame is accepted normally.
